// File: rtl/enum_rr_arbiter.sv
// Round-robin arbiter sharing one resource between three requesters (A, B, C),
// with a bounded hold time and a one-cycle cooldown between owners.
package p;
  typedef enum logic [1:0] {NONE = 2'd0, A = 2'd1, B = 2'd2, C = 2'd3} test_enum;
endpackage

module enum_rr_arbiter #(
  parameter int MAX_HOLD = 10,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [2:0]       req,
  output logic             grant_valid,
  output logic [1:0]       grant_id,
  output logic [7:0]       hold_cnt,
  output logic             timeout,
  output logic [CNT_W-1:0] grants_total
);

  typedef enum logic [1:0] {IDLE, GRANT, COOLDOWN} state_t;

  localparam logic [7:0] HOLD_LIMIT = 8'(MAX_HOLD);

  state_t          state, state_nxt;
  p::test_enum     owner, owner_nxt;
  p::test_enum     last_id, last_nxt;
  p::test_enum     winner;
  logic [7:0]      hold_nxt;
  logic            valid_nxt;
  logic            timeout_nxt;
  logic [CNT_W-1:0] total_nxt;
  logic            owner_req;

  always_comb begin
    owner_req = 1'b0;
    case (owner)
      p::A:    owner_req = req[0];
      p::B:    owner_req = req[1];
      p::C:    owner_req = req[2];
      default: owner_req = 1'b0;
    endcase
  end

  // Scan starts just after the previous owner, so a preempted owner goes last.
  always_comb begin
    winner = p::NONE;
    case (last_id)
      p::A: begin
        if (req[1])      winner = p::B;
        else if (req[2]) winner = p::C;
        else if (req[0]) winner = p::A;
      end
      p::B: begin
        if (req[2])      winner = p::C;
        else if (req[0]) winner = p::A;
        else if (req[1]) winner = p::B;
      end
      default: begin
        if (req[0])      winner = p::A;
        else if (req[1]) winner = p::B;
        else if (req[2]) winner = p::C;
      end
    endcase
  end

  always_comb begin
    state_nxt   = state;
    owner_nxt   = owner;
    last_nxt    = last_id;
    hold_nxt    = hold_cnt;
    valid_nxt   = grant_valid;
    timeout_nxt = 1'b0;
    total_nxt   = grants_total;
    case (state)
      IDLE: begin
        if (winner != p::NONE) begin
          state_nxt = GRANT;
          owner_nxt = winner;
          last_nxt  = winner;
          valid_nxt = 1'b1;
          hold_nxt  = 8'd1;
          total_nxt = grants_total + CNT_W'(1);
        end
      end
      GRANT: begin
        // Release and preemption share the exit; only preemption flags timeout.
        if (!owner_req || hold_cnt >= HOLD_LIMIT) begin
          state_nxt   = COOLDOWN;
          owner_nxt   = p::NONE;
          valid_nxt   = 1'b0;
          hold_nxt    = 8'd0;
          timeout_nxt = owner_req;
        end else begin
          hold_nxt = hold_cnt + 8'd1;
        end
      end
      COOLDOWN: state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      owner        <= p::NONE;
      last_id      <= p::C;
      hold_cnt     <= 8'd0;
      grant_valid  <= 1'b0;
      timeout      <= 1'b0;
      grants_total <= '0;
    end else begin
      state        <= state_nxt;
      owner        <= owner_nxt;
      last_id      <= last_nxt;
      hold_cnt     <= hold_nxt;
      grant_valid  <= valid_nxt;
      timeout      <= timeout_nxt;
      grants_total <= total_nxt;
    end
  end

  assign grant_id = owner;

endmodule

// File: tb/tb_enum_rr_arbiter.sv
// Bench for enum_rr_arbiter: two instances (default and MAX_HOLD=1/CNT_W=4)
// checked every cycle against a cycle-count reference model plus literal checkpoints.
module tb_enum_rr_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] req = 3'b000;
  logic [2:0] req2 = 3'b000;

  logic       gv1, gv2, to1, to2;
  logic [1:0] id1, id2;
  logic [7:0] hc1, hc2;
  logic [15:0] tot1;
  logic [3:0]  tot2;

  enum_rr_arbiter #(.MAX_HOLD(10), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .req(req),
    .grant_valid(gv1), .grant_id(id1), .hold_cnt(hc1),
    .timeout(to1), .grants_total(tot1)
  );

  enum_rr_arbiter #(.MAX_HOLD(1), .CNT_W(4)) dut2 (
    .clk(clk), .rst_n(rst_n), .req(req2),
    .grant_valid(gv2), .grant_id(id2), .hold_cnt(hc2),
    .timeout(to2), .grants_total(tot2)
  );

  always #5 clk = ~clk;

  // owner 0 = nobody; idle_wait = cycles left before arbitration may run again.
  typedef struct {
    int owner;
    int held;
    int idle_wait;
    int last;
    int count;
    int to;
  } model_t;

  model_t m1, m2;
  int     total = 0;
  int     bad = 0;
  bit     chk_en = 1'b0;

  function automatic model_t model_reset();
    model_t m;
    m.owner = 0; m.held = 0; m.idle_wait = 0; m.last = 3; m.count = 0; m.to = 0;
    return m;
  endfunction

  function automatic model_t model_next(model_t m, logic [2:0] r, int maxh, int cntw);
    model_t n = m;
    n.to = 0;
    if (m.owner != 0) begin
      if (r[m.owner-1] == 1'b0 || m.held == maxh) begin
        n.to        = (r[m.owner-1] == 1'b1) ? 1 : 0;
        n.owner     = 0;
        n.held      = 0;
        n.idle_wait = 1;
      end else begin
        n.held = m.held + 1;
      end
    end else if (m.idle_wait > 0) begin
      n.idle_wait = m.idle_wait - 1;
    end else if (r != 3'b000) begin
      for (int k = 1; k <= 3; k++) begin
        int cand;
        cand = ((m.last + k - 1) % 3) + 1;
        if (n.owner == 0 && r[cand-1] == 1'b1) n.owner = cand;
      end
      n.held  = 1;
      n.last  = n.owner;
      n.count = (m.count + 1) % (1 << cntw);
    end
    return n;
  endfunction

  task automatic checkOutput(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("[TB] FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic expectState(input string tag, input int v, input int id, input int h, input int t);
    checkOutput({tag, "_valid"}, int'(gv1), v);
    checkOutput({tag, "_id"}, int'(id1), id);
    checkOutput({tag, "_hold"}, int'(hc1), h);
    checkOutput({tag, "_timeout"}, int'(to1), t);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [2:0] r, input logic [2:0] r2);
    req  = r;
    req2 = r2;
  endtask

  // Reset asserted mid-cycle, released #1 after an edge with requests cleared.
  task automatic doReset();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    applyStimulus(3'b000, 3'b000);
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m1 = model_reset();
      m2 = model_reset();
    end else begin
      m1 = model_next(m1, req, 10, 16);
      m2 = model_next(m2, req2, 1, 4);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      checkOutput("m1_valid", int'(gv1), (m1.owner != 0) ? 1 : 0);
      checkOutput("m1_id", int'(id1), m1.owner);
      checkOutput("m1_hold", int'(hc1), m1.held);
      checkOutput("m1_timeout", int'(to1), m1.to);
      checkOutput("m1_total", int'(tot1), m1.count);
      checkOutput("m2_valid", int'(gv2), (m2.owner != 0) ? 1 : 0);
      checkOutput("m2_id", int'(id2), m2.owner);
      checkOutput("m2_hold", int'(hc2), m2.held);
      checkOutput("m2_timeout", int'(to2), m2.to);
      checkOutput("m2_total", int'(tot2), m2.count);
    end
  end

  initial begin
    m1 = model_reset();
    m2 = model_reset();
    tick();
    expectState("reset", 0, 0, 0, 0);
    checkOutput("reset_total", int'(tot1), 0);
    chk_en = 1'b1;

    // All three requesting: A, B, C each held to the limit with 2-cycle gaps.
    doReset();
    applyStimulus(3'b111, 3'b000);
    tick(); expectState("s1_a_first", 1, 1, 1, 0);
    repeat (9) tick();
    expectState("s1_a_hold10", 1, 1, 10, 0);
    tick(); expectState("s1_a_preempt", 0, 0, 0, 1);
    tick(); expectState("s1_gap2", 0, 0, 0, 0);
    tick(); expectState("s1_b_first", 1, 2, 1, 0);
    repeat (9) tick();
    expectState("s1_b_hold10", 1, 2, 10, 0);
    tick(); expectState("s1_b_preempt", 0, 0, 0, 1);
    tick();
    tick(); expectState("s1_c_first", 1, 3, 1, 0);
    checkOutput("s1_total", int'(tot1), 3);

    // B pulsed for four cycles.
    doReset();
    applyStimulus(3'b010, 3'b000);
    for (int h = 1; h <= 4; h++) begin
      tick();
      expectState("s2_b", 1, 2, h, 0);
    end
    applyStimulus(3'b000, 3'b000);
    tick(); expectState("s2_cooldown", 0, 0, 0, 0);
    tick(); expectState("s2_idle", 0, 0, 0, 0);
    checkOutput("s2_total", int'(tot1), 1);

    // Sole requester C is re-granted after preemption.
    doReset();
    applyStimulus(3'b100, 3'b000);
    repeat (10) tick();
    expectState("s3_c_hold10", 1, 3, 10, 0);
    tick(); expectState("s3_preempt", 0, 0, 0, 1);
    tick();
    tick(); expectState("s3_regrant", 1, 3, 1, 0);
    checkOutput("s3_total2", int'(tot1), 2);
    repeat (12) tick();
    expectState("s3_third", 1, 3, 1, 0);
    checkOutput("s3_total3", int'(tot1), 3);

    // A drops while B and C rise on the same edge.
    doReset();
    applyStimulus(3'b001, 3'b000);
    tick();
    tick();
    applyStimulus(3'b110, 3'b000);
    tick(); expectState("s4_cooldown", 0, 0, 0, 0);
    tick();
    tick(); expectState("s4_b_wins", 1, 2, 1, 0);
    applyStimulus(3'b101, 3'b000);
    tick();
    tick();
    tick(); expectState("s4_c_before_a", 1, 3, 1, 0);

    // Asynchronous reset in the middle of a grant.
    doReset();
    applyStimulus(3'b001, 3'b000);
    repeat (5) tick();
    expectState("s5_pre", 1, 1, 5, 0);
    #2;
    rst_n = 1'b0;
    #1;
    expectState("s5_async", 0, 0, 0, 0);
    checkOutput("s5_async_total", int'(tot1), 0);
    tick();
    rst_n = 1'b1;
    applyStimulus(3'b101, 3'b000);
    tick(); expectState("s5_a_first", 1, 1, 1, 0);

    // MAX_HOLD=1, CNT_W=4 instance: timeout on every grant, counter wraps.
    doReset();
    applyStimulus(3'b000, 3'b001);
    for (int g = 1; g <= 17; g++) begin
      tick();
      checkOutput("w_valid", int'(gv2), 1);
      checkOutput("w_hold", int'(hc2), 1);
      if (g == 15) checkOutput("w_total15", int'(tot2), 15);
      if (g == 16) checkOutput("w_total_wrap", int'(tot2), 0);
      if (g == 17) checkOutput("w_total17", int'(tot2), 1);
      tick();
      checkOutput("w_timeout", int'(to2), 1);
      tick();
    end

    // Randomized traffic on both instances, with occasional async resets.
    doReset();
    for (int i = 0; i < 3000; i++) begin
      tick();
      if ($urandom_range(7) == 0) req  = 3'($urandom_range(7));
      if ($urandom_range(3) == 0) req2 = 3'($urandom_range(7));
      if ($urandom_range(400) == 0) begin
        #2;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
      end
    end

    tick();
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/enum_rr_arbiter.md
Name: enum_rr_arbiter

Overview:
- Round-robin arbiter that shares one resource between three requesters.
- Requesters are identified by the `p::test_enum` codes A=1, B=2, C=3; code 0 means "no owner".
- Sequences ownership through a small FSM with a bounded hold time and a one-cycle cooldown between owners.
- Sits in front of any shared datapath that consumes a `test_enum`-typed select; the regression bench drives it from `clk` and checks grants against expected enum values.

Parameters:
- MAX_HOLD, 10, maximum consecutive cycles one owner may hold the grant (legal range 1..255).
- CNT_W, 16, width of the wrapping total-grant counter.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rst_n  input  1  asynchronous active-low reset.
- req  input  3  level requests; bit0=A, bit1=B, bit2=C.
- grant_valid  output  1  resource currently owned.
- grant_id  output  2  owner code (1=A, 2=B, 3=C); 0 when grant_valid=0.
- hold_cnt  output  8  cycles the current owner has held the grant, starting at 1.
- timeout  output  1  one-cycle pulse when an owner is preempted at MAX_HOLD.
- grants_total  output  CNT_W  number of grants issued since reset; wraps modulo 2^CNT_W.

Behaviour:
- Reset (async, rst_n=0), registered outputs:
  - grant_valid=0, grant_id=0, hold_cnt=0, timeout=0, grants_total=0.
  - state=IDLE; internal last_id=C (3), so A has first priority after reset.
  - Release of reset is sampled synchronously; the first arbitration happens at the first posedge with rst_n=1.
- States: IDLE, GRANT, COOLDOWN. All outputs are registered.
- IDLE:
  - If req==0, stay in IDLE.
  - Otherwise select the first requester scanning round-robin after last_id (after A: B,C,A; after B: C,A,B; after C: A,B,C).
  - Next cycle: state=GRANT, grant_valid=1, grant_id=winner, hold_cnt=1, grants_total+=1, last_id=winner.
  - Latency: req rising at edge N gives grant_valid=1 after edge N+1.
- GRANT, evaluated each edge against req[owner]:
  - req[owner]=0: go to COOLDOWN; grant_valid=0, grant_id=0, hold_cnt=0.
  - req[owner]=1 and hold_cnt<MAX_HOLD: hold_cnt+=1, stay in GRANT.
  - req[owner]=1 and hold_cnt==MAX_HOLD: preempt. Go to COOLDOWN, timeout=1 for exactly that one cycle, grant_valid=0, grant_id=0, hold_cnt=0.
  - Requests from non-owners are ignored while in GRANT.
- COOLDOWN:
  - Lasts exactly one cycle with grant_valid=0 and timeout cleared on the following edge.
  - Then IDLE, which arbitrates on the next edge.
  - Gap between owners is therefore 2 cycles with grant_valid=0.
- Round-robin fairness: a preempted owner still asserting req loses priority to any other active requester. It is re-granted only if it is the sole requester.
- MAX_HOLD=1: every grant lasts one cycle; if req is held, timeout pulses on every grant.
- grants_total wraps from 2^CNT_W-1 to 0 without flagging.
- Reset mid-grant: outputs clear immediately (asynchronously); last_id returns to C.
- No combinational path from req to any output.

Test Plan:
- Reset then req=3'b111 held constant, MAX_HOLD=10:
  - grant_id sequence is 1 (10 cycles), gap 2, 2 (10 cycles), gap 2, 3 (10 cycles).
  - timeout pulses 3 times, one cycle after each hold_cnt==10.
- req=3'b010 pulsed for 4 cycles then dropped:
  - grant_valid=1 with grant_id=2 and hold_cnt 1..4.
  - Then COOLDOWN and IDLE; timeout stays 0; grants_total=1.
- Sole requester C held for 25 cycles, MAX_HOLD=10:
  - Grant 3 for 10 cycles, timeout, 2-cycle gap, grant 3 again (re-granted as sole requester).
  - grants_total=2 after that second grant, 3 after the third.
- Simultaneous events: during A's grant, raise B and C while A drops req on the same edge:
  - COOLDOWN, then B granted, not C.
  - After B drops, C granted before A.
- Async reset asserted mid-cycle during a grant with hold_cnt=5:
  - All outputs read 0 before the next clk edge.
  - After release with req=3'b101, A (1) is granted first.
- CNT_W=4 override, sole requester A toggling req 1/0 for 17 grants:
  - grants_total wraps 15→0 and reads 1 after the 17th grant.
